// File: rtl/rca_pkg.sv
// Shared widths and default latency for the RCA adder and its result collector.
// Keeping them here lets the adder, the collector and the bench agree on latency.
package rca_pkg;
  localparam int RCA_W       = 4;
  localparam int RES_W       = RCA_W + 1;
  localparam int RCA_LAT_DEF = 4;

  typedef logic [RES_W-1:0] rca_res_t;
endpackage

// File: rtl/rca_res_fifo.sv
// Generic first-word-fall-through FIFO: dout always shows the head entry.
// A push while full is accepted only if the head is popped on the same edge.
module rca_res_fifo #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage carries no reset; only the pointers and occupancy define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/rca_result_collector.sv
// Capture stage behind the pipelined RCA: a valid delay line marks real results,
// which are buffered in a FWFT FIFO and returned as issue credit to the source.
module rca_result_collector
  import rca_pkg::*;
#(
  parameter int LAT   = RCA_LAT_DEF,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  input  logic [RCA_W-1:0]       sum,
  input  logic                   cout,
  output logic                   issue_ready,
  output logic                   out_valid,
  output rca_res_t               out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int IFW = $clog2(LAT + 1);
  localparam int SW  = ((CW > IFW) ? CW : IFW) + 1;

  // Handshake: the consumer takes the head on any edge where out_valid && out_ready.
  logic [LAT-1:0] vpipe_q, vpipe_d;
  logic [IFW-1:0] in_flight_q, in_flight_d;
  logic           overflow_q, overflow_d;
  logic           arrive, pop_fire, fifo_full, fifo_empty;
  logic [SW-1:0]  credit_used;

  assign arrive      = vpipe_q[LAT-1];
  assign out_valid   = !fifo_empty;
  assign pop_fire    = out_valid && out_ready;
  assign overflow    = overflow_q;
  assign credit_used = SW'(count) + SW'(in_flight_q);
  assign issue_ready = (credit_used < SW'(DEPTH));

  always_comb begin
    vpipe_d     = (vpipe_q << 1) | LAT'(in_valid);
    in_flight_d = in_flight_q;
    case ({in_valid, arrive})
      2'b10:   in_flight_d = in_flight_q + IFW'(1);
      2'b01:   in_flight_d = in_flight_q - IFW'(1);
      default: in_flight_d = in_flight_q;
    endcase
    // A result landing on a full FIFO is lost unless the head leaves on the same edge.
    overflow_d = overflow_q | (arrive & fifo_full & ~pop_fire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe_q     <= '0;
      in_flight_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      vpipe_q     <= vpipe_d;
      in_flight_q <= in_flight_d;
      overflow_q  <= overflow_d;
    end
  end

  rca_res_fifo #(
    .W     (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (arrive),
    .pop   (pop_fire),
    .din   ({cout, sum}),
    .dout  (out_data),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );
endmodule

// File: tb/tb_rca_result_collector.sv
// Bench for rca_result_collector: a behavioural RCA pipeline feeds the DUT and a
// queue-based model of issues, arrivals and FIFO contents supplies expectations.
module tb_rca_result_collector;
  import rca_pkg::*;

  localparam int LAT   = RCA_LAT_DEF;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [RCA_W-1:0] a, b;
  logic             cin;
  logic [RCA_W-1:0] sum;
  logic             cout;
  logic             issue_ready;
  logic             out_valid;
  rca_res_t         out_data;
  logic             out_ready;
  logic [CW-1:0]    count;
  logic             overflow;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [RES_W-1:0] exp_q[$];
  int               pend_t[$];
  logic [RES_W-1:0] pend_r[$];
  logic             m_ovf;
  int               ecnt;

  logic [3:0] va [6] = '{4'b0000, 4'b0001, 4'b0011, 4'b0101, 4'b1111, 4'b1010};
  logic [3:0] vb [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0001, 4'b1010};
  logic       vc [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [4:0] vexp [6] = '{5'b00001, 5'b00010, 5'b00110, 5'b01011, 5'b10001, 5'b10100};

  // Behavioural RCA: result of operands sampled at edge k is on sum/cout after edge k+LAT-1.
  logic [RES_W-1:0] rca_pipe [LAT];
  always @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) rca_pipe[i] <= rca_pipe[i-1];
    rca_pipe[0] <= 5'(a) + 5'(b) + 5'(cin);
  end
  assign {cout, sum} = rca_pipe[LAT-1];

  rca_result_collector #(.LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .sum         (sum),
    .cout        (cout),
    .issue_ready (issue_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .count       (count),
    .overflow    (overflow)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    exp_q.delete();
    pend_t.delete();
    pend_r.delete();
    m_ovf = 1'b0;
    ecnt  = 0;
  endtask

  // Driver: present inputs for one edge, advance the model at that edge, stop at the next negedge.
  task automatic drive(input logic iv, input logic [3:0] ta, input logic [3:0] tbv,
                       input logic tc, input logic ordy);
    logic [RES_W-1:0] r;
    logic             pop_now, arr_now;
    in_valid  = iv;
    a         = ta;
    b         = tbv;
    cin       = tc;
    out_ready = ordy;
    @(posedge clk);
    ecnt++;
    pop_now = (exp_q.size() > 0) && ordy;
    arr_now = (pend_t.size() > 0) && (pend_t[0] + LAT == ecnt);
    if (pop_now) void'(exp_q.pop_front());
    if (arr_now) begin
      r = pend_r.pop_front();
      void'(pend_t.pop_front());
      if (exp_q.size() < DEPTH) exp_q.push_back(r);
      else m_ovf = 1'b1;
    end
    if (iv) begin
      pend_t.push_back(ecnt);
      pend_r.push_back(5'(int'(ta) + int'(tbv) + int'(tc)));
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (count !== '0) begin failures++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (issue_ready !== 1'b1) begin failures++; $display("FAIL reset_issue_ready: got %b expected 1", issue_ready); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_back_to_back();
    int got_n;
    got_n = 0;
    for (int n = 1; n <= 6 + LAT + 4; n++) begin
      if (n <= 6) drive(1'b1, va[n-1], vb[n-1], vc[n-1], 1'b1);
      else        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
      checks++;
      if (out_valid !== (exp_q.size() > 0)) begin
        failures++; $display("FAIL b2b_out_valid cycle %0d: got %b expected %b", n, out_valid, exp_q.size() > 0);
      end
      if (out_valid === 1'b1 && got_n < 6) begin
        if (got_n == 0) begin
          checks++;
          if (n != LAT + 1) begin failures++; $display("FAIL b2b_latency: first result after %0d edges expected %0d", n, LAT + 1); end
        end
        checks++;
        if (out_data !== vexp[got_n]) begin
          failures++; $display("FAIL b2b_data[%0d]: got %b expected %b", got_n, out_data, vexp[got_n]);
        end
        got_n++;
      end
    end
    checks++; if (got_n != 6) begin failures++; $display("FAIL b2b_result_count: got %0d expected 6", got_n); end
  endtask

  // Issue the first four table vectors honouring issue_ready with the consumer stalled.
  task automatic fill_four(output int accepted);
    accepted = 0;
    for (int cyc = 0; cyc < 20 && accepted < 4; cyc++) begin
      if (issue_ready) begin
        drive(1'b1, va[accepted], vb[accepted], vc[accepted], 1'b0);
        accepted++;
      end else begin
        drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic test_credit();
    int acc;
    fill_four(acc);
    checks++; if (acc != 4) begin failures++; $display("FAIL credit_accepted: got %0d expected 4", acc); end
    checks++; if (issue_ready !== 1'b0) begin failures++; $display("FAIL credit_issue_ready_low: got %b expected 0", issue_ready); end
    for (int i = 0; i < LAT; i++) begin
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      checks++;
      if (issue_ready !== 1'b0) begin failures++; $display("FAIL credit_hold[%0d]: got %b expected 0", i, issue_ready); end
    end
    checks++; if (count !== CW'(4)) begin failures++; $display("FAIL credit_count_full: got %0d expected 4", count); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL credit_overflow: got %b expected 0", overflow); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== vexp[i]) begin
        failures++; $display("FAIL credit_drain[%0d]: got v=%b d=%b expected v=1 d=%b", i, out_valid, out_data, vexp[i]);
      end
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    end
    checks++;
    if (count !== '0 || out_valid !== 1'b0 || issue_ready !== 1'b1) begin
      failures++; $display("FAIL credit_empty: got count=%0d v=%b ir=%b expected 0 0 1", count, out_valid, issue_ready);
    end
  endtask

  task automatic test_overflow();
    int acc;
    fill_four(acc);
    repeat (LAT) drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    drive(1'b1, va[4], vb[4], vc[4], 1'b0);
    repeat (LAT - 1) drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_before_arrival: got %b expected 0", overflow); end
    drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    checks++; if (count !== CW'(4)) begin failures++; $display("FAIL ovf_count: got %0d expected 4", count); end
    checks++; if (out_data !== vexp[0]) begin failures++; $display("FAIL ovf_head: got %b expected %b", out_data, vexp[0]); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_data !== vexp[i]) begin failures++; $display("FAIL ovf_drain[%0d]: got %b expected %b", i, out_data, vexp[i]); end
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    end
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    do_reset();
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_reset_clear: got %b expected 0", overflow); end
  endtask

  task automatic test_full_pop_wrap();
    for (int i = 0; i < 4; i++)
      drive(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
    repeat (LAT) drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checks++; if (count !== CW'(4)) begin failures++; $display("FAIL wrap_fill: got %0d expected 4", count); end
    for (int w = 0; w < 12; w++) begin
      drive(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b0);
      repeat (LAT - 2) drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      // Pop lands on the arrival edge.
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
      checks++;
      if (count !== CW'(4) || overflow !== 1'b0 || out_data !== exp_q[0]) begin
        failures++; $display("FAIL wrap_iter[%0d]: got count=%0d ovf=%b d=%b expected 4 0 %b", w, count, overflow, out_data, exp_q[0]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
        failures++; $display("FAIL wrap_drain[%0d]: got v=%b d=%b expected v=1 d=%b", i, out_valid, out_data, exp_q[0]);
      end
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b1);
    end
  endtask

  task automatic test_random();
    logic iv;
    do_reset();
    for (int n = 0; n < 300; n++) begin
      iv = issue_ready ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
      drive(iv, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0) ? 1'b0 : 1'b1);
      checks++;
      if (out_valid !== (exp_q.size() > 0) || count !== CW'(exp_q.size()) || overflow !== m_ovf ||
          issue_ready !== ((exp_q.size() + pend_t.size()) < DEPTH) ||
          (exp_q.size() > 0 && out_data !== exp_q[0])) begin
        failures++;
        $display("FAIL random[%0d]: got v=%b d=%b cnt=%0d ovf=%b ir=%b expected cnt=%0d ovf=%b inflight=%0d",
                 n, out_valid, out_data, count, overflow, issue_ready, exp_q.size(), m_ovf, pend_t.size());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b1, va[0], vb[0], vc[0], 1'b0);
    drive(1'b1, va[1], vb[1], vc[1], 1'b0);
    repeat (LAT) drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    drive(1'b1, va[2], vb[2], vc[2], 1'b0);
    drive(1'b1, va[3], vb[3], vc[3], 1'b0);
    checks++; if (count !== CW'(2)) begin failures++; $display("FAIL midrst_pre_count: got %0d expected 2", count); end
    rst_n = 1'b0;
    in_valid = 1'b0;
    model_clear();
    #1;
    checks++;
    if (out_valid !== 1'b0 || count !== '0 || issue_ready !== 1'b1 || overflow !== 1'b0) begin
      failures++; $display("FAIL midrst_immediate: got v=%b cnt=%0d ir=%b ovf=%b expected 0 0 1 0", out_valid, count, issue_ready, overflow);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT + 2; i++) begin
      drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
      checks++;
      if (out_valid !== 1'b0 || count !== '0) begin
        failures++; $display("FAIL midrst_no_capture[%0d]: got v=%b cnt=%0d expected 0 0", i, out_valid, count);
      end
    end
    drive(1'b1, 4'b0101, 4'b0110, 1'b0, 1'b0);
    repeat (LAT) drive(1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 5'b01011 || count !== CW'(1)) begin
      failures++; $display("FAIL midrst_after: got v=%b d=%b cnt=%0d expected 1 01011 1", out_valid, out_data, count);
    end
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    rst_n = 1'b0;
    model_clear();
    test_reset();
    test_back_to_back();
    test_credit();
    test_overflow();
    test_full_pop_wrap();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
